// File: rtl/mul_iter_su.sv
// Iterative WIDTH x WIDTH multiplier with per-operand signedness.
// Define MUL_RADIX4_EN for the radix-4 Booth datapath (default radix-2).
module mul_iter_su #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               x_signed,
  input  logic               y_signed,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid,
  output logic               busy
);

  localparam int AW = 2*WIDTH+1;
  localparam int CW = $clog2(WIDTH+1);
`ifdef MUL_RADIX4_EN
  localparam int LAST = WIDTH/2;
  localparam int YW   = WIDTH+2;
`else
  localparam int LAST = WIDTH-1;
  localparam int YW   = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0] x_ext;
  logic [AW-1:0]  xs;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  acc_nx;
  logic [YW-1:0]  ysh;
  logic           yb;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(LAST));
  assign xs     = {{(AW-WIDTH-1){x_ext[WIDTH]}}, x_ext};

`ifdef MUL_RADIX4_EN
  logic [AW-1:0] term;
  logic          neg;

  // Booth digit from {y[2i+1], y[2i], y[2i-1]} scales x into acc
  always_comb begin
    term = '0;
    neg  = 1'b0;
    unique case ({ysh[1:0], yb})
      3'b001, 3'b010: term = xs;
      3'b011:         term = xs << 1;
      3'b100: begin
        term = xs << 1;
        neg  = 1'b1;
      end
      3'b101, 3'b110: begin
        term = xs;
        neg  = 1'b1;
      end
      default:        term = '0;
    endcase
    if (neg)
      acc_nx = acc - (term << {cnt, 1'b0});
    else
      acc_nx = acc + (term << {cnt, 1'b0});
  end
`else
  // Shift-add; signed multiplier MSB carries negative weight
  always_comb begin
    acc_nx = acc;
    if (ysh[0]) begin
      if (last && yb)
        acc_nx = acc - (xs << cnt);
      else
        acc_nx = acc + (xs << cnt);
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state: accept from IDLE/DONE, finish after last step
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last)   state_d = DONE;
      DONE:    if (accept) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  // Datapath, handshake flags and held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      cnt       <= '0;
      x_ext     <= '0;
      ysh       <= '0;
      yb        <= 1'b0;
    end else begin
      busy     <= (state_d == CALC);
      in_ready <= (state_d != CALC);
      if (accept) begin
        x_ext     <= {x_signed & x[WIDTH-1], x};
        acc       <= '0;
        cnt       <= '0;
        out_valid <= 1'b0;
`ifdef MUL_RADIX4_EN
        ysh <= {{2{y_signed & y[WIDTH-1]}}, y};
        yb  <= 1'b0;
`else
        ysh <= y;
        yb  <= y_signed;
`endif
      end else if (state_q == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
`ifdef MUL_RADIX4_EN
        ysh <= ysh >> 2;
        yb  <= ysh[1];
`else
        ysh <= ysh >> 1;
`endif
        if (last) begin
          p         <= acc_nx[2*WIDTH-1:0];
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
